// File: rtl/btn_pkg.sv
// Shared state type and default 50 MHz timing constants for the button conditioner.
// Optional auto-repeat is selected by BTN_AUTOREPEAT_EN in button_conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_t;

    localparam int unsigned DEBOUNCE_20MS = 1_000_000;
    localparam int unsigned HOLD_500MS    = 25_000_000;
    localparam int unsigned REPEAT_100MS  = 5_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// 2-FF synchronizer plus debounce counter; held rises/falls DEBOUNCE_CYCLES after s settles.
// rise/fall are combinational one-cycle strobes, asserted on the edge where held will change.
module btn_sync_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic held,
    output logic rise,
    output logic fall
);

    localparam logic RELEASED_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             accept;
    logic [CNT_W-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RELEASED_LVL;
            sync2 <= RELEASED_LVL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Normalised so that 1 always means "pressed" regardless of pin polarity.
    assign s      = sync2 ^ RELEASED_LVL;
    assign accept = (s != held) && (dcnt == DCNT_LAST);
    assign rise   = accept & s;
    assign fall   = accept & ~s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
            held <= 1'b0;
        end else if (s == held) begin
            dcnt <= '0;
        end else if (accept) begin
            held <= s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Raw button -> registered press/release/repeat pulses; press lands with held, 2+DEBOUNCE_CYCLES after the pin settles.
// Auto-repeat (REPEAT state, hold counter) exists only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int HOLD_CYCLES     = HOLD_500MS,
    parameter int REPEAT_CYCLES   = REPEAT_100MS,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press,
    // "release" is a reserved word, hence the _p suffix shared with repeat_p.
    output logic release_p,
    output logic repeat_p,
    output logic held,
    output logic event_p
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    logic       rise;
    logic       fall;
    btn_state_t state;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .held    (held),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef BTN_AUTOREPEAT_EN

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] hcnt;

    // Release is checked first so a terminal hcnt in the release cycle never emits a repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            press     <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
            event_p   <= 1'b0;
        end else begin
            press     <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
            event_p   <= 1'b0;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    if (rise) begin
                        press   <= 1'b1;
                        event_p <= 1'b1;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        hcnt      <= '0;
                        state     <= IDLE;
                    end else if (hcnt == HOLD_LAST) begin
                        repeat_p <= 1'b1;
                        event_p  <= 1'b1;
                        hcnt     <= '0;
                        state    <= REPEAT;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        hcnt      <= '0;
                        state     <= IDLE;
                    end else if (hcnt == REPEAT_LAST) begin
                        repeat_p <= 1'b1;
                        event_p  <= 1'b1;
                        hcnt     <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    hcnt  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`else

    assign repeat_p = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            press     <= 1'b0;
            release_p <= 1'b0;
            event_p   <= 1'b0;
        end else begin
            press     <= 1'b0;
            release_p <= 1'b0;
            event_p   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        press   <= 1'b1;
                        event_p <= 1'b1;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: per-cycle window-based reference model plus directed scenario checks.
// Expectations follow BTN_AUTOREPEAT_EN as compiled.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 3;
    localparam int AL = 1;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int HIST = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b1;
    logic press, release_p, repeat_p, held, event_p;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: raw pressed history by edge, and derived model outputs.
    bit hist [HIST];
    int n;
    bit held_m;
    int press_edge;
    bit press_m, rel_m, rep_m;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .ACTIVE_LOW      (AL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .press     (press),
        .release_p (release_p),
        .repeat_p  (repeat_p),
        .held      (held),
        .event_p   (event_p)
    );

    always #5 clk = ~clk;

    function automatic logic pin(input bit pressed);
        return pressed ^ (AL != 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < HIST; i++) hist[i] = 1'b0;
        n = 0;
        held_m = 1'b0;
        press_edge = 0;
        press_m = 1'b0;
        rel_m = 1'b0;
        rep_m = 1'b0;
    endtask

    // One clock: drive the pin, advance the model from the rules, compare all outputs.
    task automatic step(input bit pressed);
        bit prev, flip;
        int d;
        logic [4:0] got, want;
        btn_raw = pin(pressed);
        @(posedge clk);
        n++;
        hist[n + 4] = pressed;
        #1;
        // Level flips once the last D synchronized samples (2 edges old) all disagree with it.
        prev = held_m;
        flip = 1'b1;
        for (int k = 0; k < D; k++)
            if (hist[n + 2 - k] == held_m) flip = 1'b0;
        if (flip) held_m = ~held_m;
        press_m = !prev && held_m;
        rel_m = prev && !held_m;
        if (press_m) press_edge = n;
        rep_m = 1'b0;
        if (AUTO && prev && held_m) begin
            d = n - press_edge;
            if (d == H || (d > H && ((d - H) % R) == 0)) rep_m = 1'b1;
        end
        got  = {press, release_p, repeat_p, held, event_p};
        want = {press_m, rel_m, rep_m, held_m, press_m | rep_m};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL model_cycle edge=%0d {press,rel,rep,held,evt} got=%b want=%b",
                     n, got, want);
        end
    endtask

    task automatic steps(input bit pressed, input int cnt);
        for (int i = 0; i < cnt; i++) step(pressed);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0;
        btn_raw = pin(1'b1);
        model_clear();
        repeat (3) @(posedge clk);
        #3;
        got = {press, release_p, repeat_p, held, event_p};
        n_cmp++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=00000", got);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1);
            n_cmp++;
            if (press !== (i == 6) || held !== (i >= 6)) begin
                n_fail++;
                $display("FAIL reset_press edge=%0d press=%b held=%b want press=%b held=%b",
                         i, press, held, i == 6, i >= 6);
            end
        end
        steps(1'b0, 15);
    endtask

    task automatic test_clean_press();
        bit want_rep;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1);
            want_rep = AUTO && (i == 16 || i == 19);
            n_cmp++;
            if (press !== (i == 6) || repeat_p !== want_rep || event_p !== ((i == 6) || want_rep)) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d press=%b rep=%b evt=%b want press=%b rep=%b",
                         i, press, repeat_p, event_p, i == 6, want_rep);
            end
        end
        // Edge 22 falls inside debounce of the release, so the repeat still fires.
        for (int i = 21; i <= 40; i++) begin
            step(1'b0);
            if (i == 22) begin
                n_cmp++;
                if (repeat_p !== AUTO) begin
                    n_fail++;
                    $display("FAIL clean_press_rep22 rep=%b want=%b", repeat_p, AUTO);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step(((i / 2) % 2) == 0);
            pulses += int'(press) + int'(release_p) + int'(repeat_p) + int'(held);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            pulses += int'(press) + int'(release_p) + int'(repeat_p) + int'(held);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_activity got=%0d want=0", pulses);
        end
    endtask

    task automatic test_release_priority();
        for (int i = 1; i <= 30; i++) begin
            step(i <= 13);
            if (i == 19) begin
                n_cmp++;
                if (release_p !== 1'b1 || repeat_p !== 1'b0 || held !== 1'b0) begin
                    n_fail++;
                    $display("FAIL release_priority rel=%b rep=%b held=%b want 1 0 0",
                             release_p, repeat_p, held);
                end
            end
        end
    endtask

    task automatic test_mid_hold_reset();
        logic [4:0] got;
        int rel_cnt;
        steps(1'b1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        got = {press, release_p, repeat_p, held, event_p};
        n_cmp++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_hold_reset_async got=%b want=00000", got);
        end
        #2;
        rst_n = 1'b1;
        model_clear();
        rel_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            rel_cnt += int'(release_p);
        end
        n_cmp++;
        if (rel_cnt != 0) begin
            n_fail++;
            $display("FAIL mid_hold_reset_stray_release got=%0d want=0", rel_cnt);
        end
    endtask

    task automatic test_long_hold();
        int np, nr, nq;
        np = 0; nr = 0; nq = 0;
        for (int i = 0; i < 55; i++) begin
            step(i < 40);
            np += int'(press);
            nr += int'(release_p);
            nq += int'(repeat_p);
        end
        n_cmp++;
        if (np != 1 || nr != 1 || nq != (AUTO ? 10 : 0)) begin
            n_fail++;
            $display("FAIL long_hold press=%0d rel=%0d rep=%0d want 1 1 %0d",
                     np, nr, nq, AUTO ? 10 : 0);
        end
    endtask

    task automatic test_random();
        int run;
        bit lvl;
        lvl = 1'b0;
        for (int blk = 0; blk < 60; blk++) begin
            lvl = ~lvl;
            run = (($urandom % 4) == 0) ? int'($urandom_range(8, 25)) : int'($urandom_range(1, 6));
            steps(lvl, run);
        end
        steps(1'b0, 12);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            steps(1'b1, D + 3 + k);
            steps(1'b0, D + 3);
        end
        steps(1'b0, 10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_priority();
        test_mid_hold_reset();
        test_long_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions one raw push-button into clean, single-cycle control events for the timer/stopwatch core (pause, mode, increment, accelerate inputs).
- Stage chain: 2-FF synchronizer -> debounce counter -> press/release edge detector -> hold timer with auto-repeat.
- One instance per button, placed directly upstream of the timer core. Auto-repeat lets a held increment button scroll minutes and seconds.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a level change (>=2).
- HOLD_CYCLES, 25_000_000: cycles from press pulse to first repeat pulse (>=1).
- REPEAT_CYCLES, 5_000_000: cycles between subsequent repeat pulses (>=1).
- ACTIVE_LOW, 1: 1 means raw input reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  1  unsynchronized button pin
- press  out  1  one-cycle pulse on accepted press
- release  out  1  one-cycle pulse on accepted release
- repeat_p  out  1  one-cycle pulse per auto-repeat tick
- held  out  1  debounced pressed level
- event_p  out  1  press OR repeat_p (drop-in for a single-pulse button input)

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - Synchronizer flops load the released level (1 if ACTIVE_LOW, else 0).
  - All counters 0; FSM in IDLE.
- Synchronizer:
  - Two flops; normalized pressed bit `s` = sync2 XOR ACTIVE_LOW.
  - Latency 2 cycles.
- Debounce:
  - Counter `dcnt` is sized $clog2 of the largest parameter plus 1.
  - When `s` == `held`: `dcnt` <= 0.
  - When `s` != `held`: `dcnt` increments. On the cycle `dcnt` == DEBOUNCE_CYCLES-1, `held` <= `s` and `dcnt` <= 0.
  - Any bounce resets the count.
  - Total press latency from the first edge sampling a stable pressed raw value to `held` rising = 2 + DEBOUNCE_CYCLES edges.
- FSM states:
  - IDLE: `held`=0.
    - -> PRESSED when the debounce accepts a 1.
    - `press`=1 in the same cycle `held` rises (both registered); `hcnt` <= 0.
  - PRESSED: `hcnt` counts each cycle.
    - When `hcnt` == HOLD_CYCLES-1: `repeat_p`=1, `hcnt` <= 0, -> REPEAT.
  - REPEAT: `hcnt` counts.
    - When `hcnt` == REPEAT_CYCLES-1: `repeat_p`=1, `hcnt` <= 0, stay in REPEAT.
  - PRESSED/REPEAT -> IDLE when the debounce accepts a 0.
    - `release`=1 in the same cycle `held` falls; `hcnt` <= 0.
    - Release has priority: no `repeat_p` in the release cycle, even if `hcnt` hits its terminal value.
- Pulse rules:
  - `press`, `release` and `repeat_p` are mutually exclusive and never wider than 1 cycle.
  - `event_p` = `press` | `repeat_p`, registered alongside them.
- Boundary conditions:
  - Glitch shorter than DEBOUNCE_CYCLES: no output activity.
  - Counters saturate at no point other than their terminal values; wrap is impossible by construction.
  - `rst_n` asserted mid-hold: all outputs drop to 0 immediately (asynchronously).
  - Button still physically held when `rst_n` deasserts: `held` rises after 2 + DEBOUNCE_CYCLES cycles and `press` fires once.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: PRESSED/REPEAT auto-repeat behaves as described above.
- Undefined:
  - REPEAT state and `hcnt` are removed.
  - PRESSED holds until release.
  - `repeat_p` is tied to 0, so `event_p` == `press`.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Shared package `btn_pkg`:
  - FSM state enum `btn_state_t` {IDLE, PRESSED, REPEAT}.
  - Default timing constants for a 50 MHz board: DEBOUNCE_20MS, HOLD_500MS, REPEAT_100MS.
- Sub-module `btn_sync_debounce`:
  - Contains synchronizer, debounce counter and `held`.
  - Exports `held` plus one-cycle rise/fall strobes.
  - The top level holds the FSM, hold counter and pulse outputs.

Test Plan:
- Parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1.
- Reset: `rst_n`=0 with `btn_raw`=0 (pressed) -> all outputs 0; after release of `rst_n`, `press` pulses exactly at edge 6 and `held`=1.
- Clean press: `btn_raw` 1->0, held 20 cycles -> `press` at edge 6, `repeat_p` at edge 16, then edges 19 and 22 (macro defined); `event_p` mirrors these pulses.
- Bounce: `btn_raw` toggles 0/1 every 2 cycles for 30 cycles, then stays 1 -> no pulses; `held` stays 0.
- Release priority: hold until `hcnt` terminal coincides with the debounce accepting release -> `release`=1, `repeat_p`=0 that cycle, FSM in IDLE.
- Mid-hold reset: assert `rst_n` low during REPEAT -> outputs 0 within the same cycle (asynchronous); no stray `release` pulse after deassertion.
- Macro undefined: hold button 40 cycles -> exactly one `press` and one `release`; `repeat_p` never asserts.
